mmio_timer_v1: RTL

MMIO_TIMER_V1 -- requirements
Module: mmio_timer_v1

---
 rtl/ivm_mmio_pkg.sv | 21 ++
 rtl/mmio_prescaler.sv | 27 ++
 rtl/mmio_timer_v1.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ivm_mmio_pkg.sv
// Shared definitions for MMIO timer slots: register offsets, CTRL bit positions, FSM states.
package ivm_mmio_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } timer_state_e;

    localparam logic [9:0] OffCtrl    = 10'h000;
    localparam logic [9:0] OffCount   = 10'h004;
    localparam logic [9:0] OffCompare = 10'h008;
    localparam logic [9:0] OffStatus  = 10'h00C;

    localparam int unsigned CtrlEnBit       = 0;
    localparam int unsigned CtrlAutoBit     = 1;
    localparam int unsigned CtrlIrqEnBit    = 2;
    localparam int unsigned CtrlPrescaleLsb = 8;
    localparam int unsigned StatusMatchBit  = 0;

endpackage

// File: rtl/mmio_prescaler.sv
// Free-running prescaler: counts 0..limit while enabled and pulses tick on the limit cycle.
module mmio_prescaler #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         tick
);

    logic [W-1:0] r_cnt;

    assign tick = enable & (r_cnt == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= tick ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/mmio_timer_v1.sv
// Memory-mapped compare timer: CTRL/COUNT/COMPARE/STATUS registers, IDLE/RUN/DONE control FSM,
// registered read data and a level interrupt on MATCH.
module mmio_timer_v1 #(
    parameter int unsigned PRESCALE_W    = 8,
    parameter logic [31:0] RESET_COMPARE = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic [9:0]  data_address,
    input  logic [31:0] data_store,
    input  logic        data_read,
    output logic [31:0] data_fetch,
    output logic        irq
);

    import ivm_mmio_pkg::*;

    timer_state_e r_state, w_state_next;

    logic                  r_en, r_auto, r_irq_en, r_match;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [31:0]           r_count, r_compare, r_fetch;

    logic        w_wr, w_rd, w_wr_ctrl, w_wr_count, w_wr_compare, w_wr_status;
    logic        w_run, w_enter_run, w_stop, w_tick, w_hit;
    logic [7:0]  w_word;
    logic [31:0] w_ctrl_rd, w_rdata;
    logic        w_unused_addr;

    // Byte-lane bits are not decoded.
    assign w_unused_addr = ^data_address[1:0];
    assign w_word        = data_address[9:2];

    assign w_wr         = sel & ~data_read;
    assign w_rd         = sel & data_read;
    assign w_wr_ctrl    = w_wr & (w_word == OffCtrl[9:2]);
    assign w_wr_count   = w_wr & (w_word == OffCount[9:2]);
    assign w_wr_compare = w_wr & (w_word == OffCompare[9:2]);
    assign w_wr_status  = w_wr & (w_word == OffStatus[9:2]);

    assign w_hit = w_tick & (r_count == r_compare);

    mmio_prescaler #(
        .W(PRESCALE_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_enter_run),
        .enable(w_run),
        .limit (r_prescale),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A software CTRL write decides the next state ahead of a same-cycle match.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_wr_ctrl && data_store[CtrlEnBit]) w_state_next = StRun;
            end
            StRun: begin
                if (w_wr_ctrl) begin
                    w_state_next = data_store[CtrlEnBit] ? StRun : StIdle;
                end else if (w_hit && !r_auto) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (w_wr_ctrl) w_state_next = data_store[CtrlEnBit] ? StRun : StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_run       = (r_state == StRun);
        w_enter_run = (r_state != StRun) && (w_state_next == StRun);
        w_stop      = (r_state == StRun) && (w_state_next == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_prescale <= '0;
        end else if (w_wr_ctrl) begin
            r_en       <= data_store[CtrlEnBit];
            r_auto     <= data_store[CtrlAutoBit];
            r_irq_en   <= data_store[CtrlIrqEnBit];
            r_prescale <= data_store[CtrlPrescaleLsb +: PRESCALE_W];
        end else if (w_stop) begin
            r_en <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= data_store;
        end else if (w_hit) begin
            if (r_auto) r_count <= '0;
        end else if (w_tick) begin
            r_count <= r_count + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_compare <= RESET_COMPARE;
        end else if (w_wr_compare) begin
            r_compare <= data_store;
        end
    end

    // A match on the same edge as a W1C keeps MATCH set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match <= 1'b0;
        end else if (w_hit) begin
            r_match <= 1'b1;
        end else if (w_wr_status && data_store[StatusMatchBit]) begin
            r_match <= 1'b0;
        end
    end

    always_comb begin
        w_ctrl_rd                                   = '0;
        w_ctrl_rd[CtrlEnBit]                        = r_en;
        w_ctrl_rd[CtrlAutoBit]                      = r_auto;
        w_ctrl_rd[CtrlIrqEnBit]                     = r_irq_en;
        w_ctrl_rd[CtrlPrescaleLsb +: PRESCALE_W]    = r_prescale;
    end

    always_comb begin
        w_rdata = '0;
        case (w_word)
            OffCtrl[9:2]:    w_rdata = w_ctrl_rd;
            OffCount[9:2]:   w_rdata = r_count;
            OffCompare[9:2]: w_rdata = r_compare;
            OffStatus[9:2]:  w_rdata[StatusMatchBit] = r_match;
            default:         w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch <= '0;
        end else begin
            r_fetch <= w_rd ? w_rdata : '0;
        end
    end

    assign data_fetch = r_fetch;
    assign irq        = r_match & r_irq_en;

endmodule
